// File: rtl/msg_arbiter.sv
// rtl/msg_arbiter.sv - round-robin message arbiter and frame builder for the shared uart tx (optional CHECKSUM_EN)
module msg_arbiter #(
  parameter int          N_SRC     = 25,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     have_msg_bus,
  input  logic [8*N_SRC-1:0]   len_bus,
  input  logic [8*N_SRC-1:0]   data_bus,
  output logic [N_SRC-1:0]     rdreq_bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [7:0]           grant_id
);

  // End-of-frame is resolved on the final handshake itself, so there is no
  // separate END state; this lets IDLE re-arbitrate on the very next cycle.
  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_ADDR,
    S_LEN,
    S_GAP,
    S_PAYLOAD,
    S_WAIT
`ifdef CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t           state, state_n;
  logic [7:0]       tx_data_n;
  logic             tx_valid_n;
  logic             busy_n;
  logic [7:0]       grant_n;
  logic [7:0]       len_r, len_n;
  logic [7:0]       rem, rem_n;
  logic [N_SRC-1:0] rdreq_n;
`ifdef CHECKSUM_EN
  logic [7:0]       csum, csum_n;
`endif

  logic             hs;
  logic             found;
  int               pick;
  int               gi;
  logic [7:0]       head;
  logic             frame_done;

  assign hs   = tx_valid & tx_ready;
  assign gi   = int'(grant_id);
  assign head = data_bus[gi*8 +: 8];

  // Round-robin search: first pending source after the last granted one.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = 0;
    idx   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = gi + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && have_msg_bus[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    state_n    = state;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    busy_n     = busy;
    grant_n    = grant_id;
    len_n      = len_r;
    rem_n      = rem;
    rdreq_n    = '0;
    frame_done = 1'b0;
`ifdef CHECKSUM_EN
    csum_n     = csum;
`endif

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n    = 8'(pick);
          len_n      = len_bus[pick*8 +: 8];
          rem_n      = len_bus[pick*8 +: 8];
          tx_data_n  = SYNC_BYTE;
          tx_valid_n = 1'b1;
          busy_n     = 1'b1;
          state_n    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (hs) begin
          tx_data_n = grant_id;
`ifdef CHECKSUM_EN
          csum_n    = grant_id;
`endif
          state_n   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (hs) begin
          tx_data_n = len_r;
`ifdef CHECKSUM_EN
          csum_n    = csum ^ len_r;
`endif
          state_n   = S_LEN;
        end
      end
      S_LEN: begin
        if (hs) begin
          if (len_r != 8'd0) begin
            tx_valid_n = 1'b0;
            state_n    = S_GAP;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      // GAP and WAIT give the slave one quiet cycle before its head byte is taken.
      S_GAP, S_WAIT: begin
        tx_data_n   = head;
        tx_valid_n  = 1'b1;
        rdreq_n[gi] = 1'b1;
        rem_n       = rem - 8'd1;
`ifdef CHECKSUM_EN
        csum_n      = csum ^ head;
`endif
        state_n     = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (hs) begin
          if (rem != 8'd0) begin
            tx_valid_n = 1'b0;
            state_n    = S_WAIT;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          tx_valid_n = 1'b0;
          busy_n     = 1'b0;
          state_n    = S_IDLE;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (frame_done) begin
`ifdef CHECKSUM_EN
      tx_data_n  = csum_n;
      tx_valid_n = 1'b1;
      state_n    = S_CSUM;
`else
      tx_valid_n = 1'b0;
      busy_n     = 1'b0;
      state_n    = S_IDLE;
`endif
    end
  end

  // State and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      rdreq_bus <= '0;
      busy      <= 1'b0;
      grant_id  <= 8'(N_SRC - 1);
      len_r     <= 8'd0;
      rem       <= 8'd0;
`ifdef CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
      rdreq_bus <= rdreq_n;
      busy      <= busy_n;
      grant_id  <= grant_n;
      len_r     <= len_n;
      rem       <= rem_n;
`ifdef CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_msg_arbiter.sv
// tb/tb_msg_arbiter.sv - directed self-checking bench for msg_arbiter
module tb_msg_arbiter;

  localparam int N = 25;
`ifdef CHECKSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   have_msg_bus;
  logic [8*N-1:0] len_bus;
  logic [8*N-1:0] data_bus;
  logic [N-1:0]   rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic [7:0]     grant_id;

  logic [7:0] mem [N][16];
  logic [3:0] ptr [N];

  logic [7:0] bytes[$];
  logic [7:0] exp_q[$];
  int rd_cnt [N];
  int rd_total;
  int min_gap;
  int last_rd;
  int cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  msg_arbiter #(.N_SRC(N), .SYNC_BYTE(8'hAA)) dut (
    .clk          (clk),
    .rst          (rst),
    .have_msg_bus (have_msg_bus),
    .len_bus      (len_bus),
    .data_bus     (data_bus),
    .rdreq_bus    (rdreq_bus),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  // Show-ahead source buffers: head byte is whatever ptr points at.
  always_comb begin
    data_bus = '0;
    for (int i = 0; i < N; i++) data_bus[i*8 +: 8] = mem[i][ptr[i]];
  end

  // Capture accepted bytes and pop pulses; advance source heads on pops.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      bytes.delete();
      for (int i = 0; i < N; i++) begin
        rd_cnt[i] = 0;
        ptr[i] <= 4'd0;
      end
      rd_total = 0;
      min_gap  = 1000;
      last_rd  = -1000;
    end else begin
      if (tx_valid && tx_ready) bytes.push_back(tx_data);
      for (int i = 0; i < N; i++) begin
        if (rdreq_bus[i]) begin
          ptr[i] <= ptr[i] + 4'd1;
          rd_cnt[i]++;
          rd_total++;
          if (cyc - last_rd < min_gap) min_gap = cyc - last_rd;
          last_rd = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    have_msg_bus = '0;
    len_bus = '0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [7:0] len);
    have_msg_bus[i] = 1'b1;
    len_bus[i*8 +: 8] = len;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t = 0;
    while (bytes.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, bytes.size() >= n, 1);
  endtask

  task automatic expect_bytes(input string tag);
    check({tag, "_count"}, bytes.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < bytes.size()) check(tag, bytes[k], exp_q[k]);
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_ready = 1'b1;
    have_msg_bus = '0;
    len_bus = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 16; j++) mem[i][j] = 8'(i * 16 + j);

    // Reset state
    do_reset();
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rdreq", rdreq_bus, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_grant_id", grant_id, 24);

    // 1: source 3, len 2
    mem[3][0] = 8'h11; mem[3][1] = 8'h22;
    set_src(3, 8'd2);
    @(negedge clk);
    check("t1_lat_valid", {31'd0, tx_valid}, 1);
    check("t1_lat_sync", tx_data, 8'hAA);
    check("t1_lat_busy", {31'd0, busy}, 1);
    check("t1_grant", grant_id, 3);
    have_msg_bus = '0;
    wait_idle("t1_idle");
    exp_q = '{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22};
`ifdef CHECKSUM_EN
    exp_q.push_back(8'h32);
`endif
    expect_bytes("t1_bytes");
    check("t1_rdreq3", rd_cnt[3], 2);
    check("t1_rdreq_total", rd_total, 2);
    check("t1_gap_ge2", min_gap >= 2, 1);

    // 2: sources 0 and 5 always pending, len 1
    do_reset();
    mem[0][0] = 8'h40; mem[0][1] = 8'h41;
    mem[5][0] = 8'h50; mem[5][1] = 8'h51;
    set_src(0, 8'd1);
    set_src(5, 8'd1);
    wait_bytes("t2_progress", 4 * (4 + XB));
    have_msg_bus = '0;
    for (int f = 0; f < 4; f++) begin
      check("t2_sync", bytes[f*(4+XB)], 8'hAA);
      check("t2_addr", bytes[f*(4+XB)+1], (f % 2 == 0) ? 8'h00 : 8'h05);
      check("t2_len", bytes[f*(4+XB)+2], 8'h01);
    end
    check("t2_pay0", bytes[3], 8'h40);
    check("t2_pay1", bytes[(4+XB)+3], 8'h50);
    check("t2_pay2", bytes[2*(4+XB)+3], 8'h41);
    check("t2_pay3", bytes[3*(4+XB)+3], 8'h51);

    // 3: stall on the LEN byte for 10 cycles
    do_reset();
    mem[7][0] = 8'h77;
    set_src(7, 8'd1);
    wait_bytes("t3_reach_len", 2);
    have_msg_bus = '0;
    tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, tx_valid}, 1);
      check("t3_hold_data", tx_data, 8'h01);
      check("t3_hold_rdreq", rdreq_bus, 0);
    end
    check("t3_stall_count", bytes.size(), 2);
    tx_ready = 1'b1;
    @(negedge clk);
    wait_idle("t3_idle");
    exp_q = '{8'hAA, 8'h07, 8'h01, 8'h77};
`ifdef CHECKSUM_EN
    exp_q.push_back(8'h71);
`endif
    expect_bytes("t3_bytes");
    check("t3_rdreq7", rd_cnt[7], 1);

    // 4: source 24, len 0
    do_reset();
    set_src(24, 8'd0);
    @(negedge clk);
    check("t4_grant", grant_id, 24);
    have_msg_bus = '0;
    wait_idle("t4_idle");
    exp_q = '{8'hAA, 8'h18, 8'h00};
`ifdef CHECKSUM_EN
    exp_q.push_back(8'h18);
`endif
    expect_bytes("t4_bytes");
    check("t4_no_rdreq", rd_total, 0);

    // 5: reset during payload of a len 5 frame
    do_reset();
    set_src(9, 8'd5);
    begin
      int t = 0;
      while (rd_cnt[9] < 2 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    check("t5_mid_payload", rd_cnt[9], 2);
    rst = 1'b1;
    have_msg_bus = '0;
    len_bus = '0;
    set_src(0, 8'd0);
    set_src(1, 8'd0);
    @(negedge clk);
    check("t5_rst_valid", {31'd0, tx_valid}, 0);
    check("t5_rst_rdreq", rdreq_bus, 0);
    check("t5_rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_first_grant", grant_id, 0);
    check("t5_first_sync", tx_data, 8'hAA);

    // 6: wrap-around from grant_id 24 with sources 2 and 24 pending
    do_reset();
    set_src(2, 8'd0);
    set_src(24, 8'd0);
    wait_bytes("t6_progress", 2 * (3 + XB));
    have_msg_bus = '0;
    check("t6_first_addr", bytes[1], 8'd2);
    check("t6_second_addr", bytes[(3+XB)+1], 8'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
